tap_controller: RTL and testbench

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/jtag_pkg.sv | 40 ++++
 rtl/tap_clock_gate.sv | 19 +
 rtl/tap_controller.sv | 105 ++++++++++
 tb/tb_tap_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings and instruction
// decode constants used by the TAP controller and the instruction register.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam int                IR_LEN     = 4;
  localparam logic [IR_LEN-1:0] IR_EXTEST  = 4'h0;
  localparam logic [IR_LEN-1:0] IR_IDCODE  = 4'h1;
  localparam logic [IR_LEN-1:0] IR_SAMPLE  = 4'h2;
  localparam logic [IR_LEN-1:0] IR_BYPASS  = 4'hF;
  localparam int                ID_LEN     = 32;
  localparam int                BYPASS_LEN = 1;

  // TLR sits in the upper nibble range but belongs to the DR side of the mux.
  function automatic logic is_ir_side(input tap_state_t s);
    case (s)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: is_ir_side = 1'b1;
      default:                                                 is_ir_side = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tap_clock_gate.sv
// Glitch-free clock gate: enable is captured on falling tck, so the AND with
// tck can only open or close while tck is low.
module tap_clock_gate (
  input  logic tck,
  input  logic trst,
  input  logic en,
  output logic gclk
);

  logic en_q;

  always_ff @(negedge tck or posedge trst) begin
    if (trst) en_q <= 1'b0;
    else      en_q <= en;
  end

  assign gclk = tck & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on rising tck, control outputs
// registered on falling tck, gated DR/IR clocks.
module tap_controller
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] tap_state,
  output logic       tap_reset,
  output logic       select,
  output logic       enable,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       clockDR,
  output logic       updateDR,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       clockIR,
  output logic       updateIR
);

  tap_state_t state, state_next;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TLR;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:      state_next = tms ? TLR      : RTI;
      RTI:      state_next = tms ? SEL_DR   : RTI;
      SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_next = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_next = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_next = tms ? SEL_DR   : RTI;
      SEL_IR:   state_next = tms ? TLR      : CAP_IR;
      CAP_IR:   state_next = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_next = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_next = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_next = tms ? SEL_DR   : RTI;
      default:  state_next = TLR;
    endcase
  end

  assign tap_state = state;

  // Controls decoded from the current state, applied half a cycle later.
  logic cap_dr_d, sh_dr_d, upd_dr_d, cap_ir_d, sh_ir_d, upd_ir_d;

  always_comb begin
    cap_dr_d = (state == CAP_DR);
    sh_dr_d  = (state == SH_DR);
    upd_dr_d = (state == UPD_DR);
    cap_ir_d = (state == CAP_IR);
    sh_ir_d  = (state == SH_IR);
    upd_ir_d = (state == UPD_IR);
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tap_reset <= 1'b1;
      select    <= 1'b0;
      enable    <= 1'b0;
      captureDR <= 1'b0;
      shiftDR   <= 1'b0;
      updateDR  <= 1'b0;
      captureIR <= 1'b0;
      shiftIR   <= 1'b0;
      updateIR  <= 1'b0;
    end else begin
      tap_reset <= (state == TLR);
      select    <= is_ir_side(state);
      enable    <= sh_dr_d | sh_ir_d;
      captureDR <= cap_dr_d;
      shiftDR   <= sh_dr_d;
      updateDR  <= upd_dr_d;
      captureIR <= cap_ir_d;
      shiftIR   <= sh_ir_d;
      updateIR  <= upd_ir_d;
    end
  end

  tap_clock_gate u_gate_dr (
    .tck  (tck),
    .trst (trst),
    .en   (cap_dr_d | sh_dr_d),
    .gclk (clockDR)
  );

  tap_clock_gate u_gate_ir (
    .tck  (tck),
    .trst (trst),
    .en   (cap_ir_d | sh_ir_d),
    .gclk (clockIR)
  );

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed scenarios plus random tms walk against a
// table-driven model of the 1149.1 state graph.
module tb_tap_controller;

  logic       tck, trst, tms;
  logic [3:0] tap_state;
  logic       tap_reset, select, enable;
  logic       captureDR, shiftDR, clockDR, updateDR;
  logic       captureIR, shiftIR, clockIR, updateIR;

  tap_controller dut (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (tap_state),
    .tap_reset (tap_reset),
    .select    (select),
    .enable    (enable),
    .captureDR (captureDR),
    .shiftDR   (shiftDR),
    .clockDR   (clockDR),
    .updateDR  (updateDR),
    .captureIR (captureIR),
    .shiftIR   (shiftIR),
    .clockIR   (clockIR),
    .updateIR  (updateIR)
  );

  // tck rises at 5, 15, 25, ... and falls at 10, 20, ...
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  int vectors = 0;
  int miscompares = 0;
  int act_cdr = 0, act_cir = 0, act_udr = 0, glitches = 0;
  int exp_cdr = 0, exp_cir = 0;
  int m_state;
  int nxt0[16];
  int nxt1[16];

  always @(posedge clockDR) act_cdr++;
  always @(posedge clockIR) act_cir++;
  always @(posedge updateDR) act_udr++;

  // Gated clocks may only move at a tck edge; reset may force them low.
  always @(clockDR or clockIR) begin
    if (tck === 1'b1 && trst === 1'b0 && ($time % 10) != 5) glitches++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {tap_reset, select, enable, capDR, shDR, updDR, capIR, shIR, updIR}
  function automatic logic [8:0] exp_ctl(input int s);
    logic ir;
    ir = (s == 4) || (s >= 8 && s <= 11) || (s == 13) || (s == 14);
    return {s == 15, ir, (s == 2) || (s == 10), s == 6, s == 2, s == 5,
            s == 14, s == 10, s == 13};
  endfunction

  function automatic void model_step(input logic t);
    if (m_state == 6 || m_state == 2)  exp_cdr++;
    if (m_state == 14 || m_state == 10) exp_cir++;
    m_state = t ? nxt1[m_state] : nxt0[m_state];
  endfunction

  task automatic check_outputs();
    logic dr_any, ir_any;
    check("ctl", {tap_reset, select, enable, captureDR, shiftDR, updateDR,
                  captureIR, shiftIR, updateIR}, exp_ctl(m_state));
    check("clk_low", {clockDR, clockIR}, 2'b00);
    dr_any = captureDR | shiftDR | updateDR | clockDR;
    ir_any = captureIR | shiftIR | updateIR | clockIR;
    check("excl", dr_any & ir_any, 1'b0);
  endtask

  // Called with tck low; returns 1 time unit after the following falling tck.
  task automatic tick(input logic t);
    tms = t;
    @(posedge tck);
    model_step(t);
    #1 check("tap_state", tap_state, m_state);
    @(negedge tck);
    #1 check_outputs();
  endtask

  int base_cdr, base_udr;

  initial begin
    // Transition table: state -> next for tms=0 / tms=1.
    nxt0[15] = 12; nxt1[15] = 15;
    nxt0[12] = 12; nxt1[12] = 7;
    nxt0[7]  = 6;  nxt1[7]  = 4;
    nxt0[6]  = 2;  nxt1[6]  = 1;
    nxt0[2]  = 2;  nxt1[2]  = 1;
    nxt0[1]  = 3;  nxt1[1]  = 5;
    nxt0[3]  = 3;  nxt1[3]  = 0;
    nxt0[0]  = 2;  nxt1[0]  = 5;
    nxt0[5]  = 12; nxt1[5]  = 7;
    nxt0[4]  = 14; nxt1[4]  = 15;
    nxt0[14] = 10; nxt1[14] = 9;
    nxt0[10] = 10; nxt1[10] = 9;
    nxt0[9]  = 11; nxt1[9]  = 13;
    nxt0[11] = 11; nxt1[11] = 8;
    nxt0[8]  = 10; nxt1[8]  = 13;
    nxt0[13] = 12; nxt1[13] = 7;

    // Reset pulse, then TLR -> RTI -> SelDR -> CapDR -> ShDR.
    tms = 1'b1;
    trst = 1'b1;
    m_state = 15;
    #2;
    check("rst_state", tap_state, 4'hF);
    check_outputs();
    @(negedge tck); #1;
    trst = 1'b0;
    tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
    check("shiftDR_on", shiftDR, 1'b1);

    // Full DR scan of 32 bits from Capture-DR, then exit and update.
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    check("at_capdr", tap_state, 4'h6);
    base_cdr = act_cdr;
    base_udr = act_udr;
    for (int i = 0; i < 32; i++) tick(1'b0);
    tick(1'b1); tick(1'b1);
    check("upd_state", tap_state, 4'h5);
    check("updateDR_on", updateDR, 1'b1);
    check("scan_edges", act_cdr - base_cdr, 33);
    check("upd_pulses", act_udr - base_udr, 1);
    tick(1'b0);
    check("updateDR_off", updateDR, 1'b0);
    check("scan_edges_after", act_cdr - base_cdr, 33);

    // Shift-IR, then five tms=1 to Test-Logic-Reset.
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    check("at_shir", tap_state, 4'hA);
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("tlr_reached", tap_state, 4'hF);
    check("tap_reset_on", tap_reset, 1'b1);

    // Asynchronous reset mid Shift-DR while tck is high.
    tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    tms = 1'b0;
    @(posedge tck);
    model_step(1'b0);
    #2;
    base_cdr = act_cdr;
    base_udr = act_udr;
    trst = 1'b1;
    m_state = 15;
    #1;
    check("abort_state", tap_state, 4'hF);
    check("abort_clk", clockDR, 1'b0);
    check("abort_shift", shiftDR, 1'b0);
    check("abort_reset", tap_reset, 1'b1);
    @(negedge tck); #1;
    check_outputs();
    @(posedge tck); #1;
    check("abort_clk_high", clockDR, 1'b0);
    @(negedge tck); #1;
    trst = 1'b0;
    check("abort_edges", act_cdr - base_cdr, 0);
    check("abort_upd", act_udr - base_udr, 0);
    tick(1'b0);
    check("post_rst_rti", tap_state, 4'hC);

    // Random walk.
    for (int i = 0; i < 10000; i++) tick(1'($urandom_range(0, 1)));
    check("cdr_edges", act_cdr, exp_cdr);
    check("cir_edges", act_cir, exp_cir);
    check("glitches", glitches, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
